// File: rtl/bitbakery_serial_pkg.sv
// Shared constants, state encoding and helpers for the BitBakery serial telemetry transmitter.
package bitbakery_serial_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned NUM_WORDS = 4;
    localparam int unsigned WORD_W    = $clog2(NUM_WORDS);

    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        INICIO   = 3'd1,
        DADOS    = 3'd2,
        PARIDADE = 3'd3,
        PARADA   = 3'd4
    } tx_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bitbakery_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module bitbakery_baud_tick
    import bitbakery_serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clear,
    output logic o_tick_c,
    output logic o_last_nx_c
);

    localparam int unsigned      CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;

    // Held at zero while disabled or when the owning FSM changes state.
    always_comb begin
        w_cnt_nx = r_cnt + CNT_W'(1);
        if (!i_en || i_clear || (r_cnt == CNT_LAST)) begin
            w_cnt_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nx;
        end
    end

    assign o_tick_c    = i_en && (r_cnt == CNT_LAST);
    assign o_last_nx_c = (w_cnt_nx == CNT_LAST);

endmodule

// File: rtl/bitbakery_serial_transmitter.sv
// Free-running UART-style transmitter cycling D0..D3, one frame per word.
// Optional even-parity bit enabled by defining BITBAKERY_TX_PARITY_EN.
module bitbakery_serial_transmitter
    import bitbakery_serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned GAP_BITS     = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] D0,
    input  logic [DATA_W-1:0] D1,
    input  logic [DATA_W-1:0] D2,
    input  logic [DATA_W-1:0] D3,
    output logic              saida_serial,
    output logic [WORD_W-1:0] db_palavra,
    output logic              fim_quadro
);

    localparam int unsigned      BIT_SPAN      = (GAP_BITS > DATA_W) ? GAP_BITS : DATA_W;
    localparam int unsigned      BIT_W         = cnt_width(BIT_SPAN);
    localparam int unsigned      GAP_LAST      = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;
    localparam logic [BIT_W-1:0] BIT_GAP_LAST  = BIT_W'(GAP_LAST);
    localparam logic [BIT_W-1:0] BIT_DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic             GAP_EN        = (GAP_BITS > 0);

    tx_state_e         r_state;
    tx_state_e         w_state_nx;
    logic              r_armed;
    logic [BIT_W-1:0]  r_bit;
    logic [BIT_W-1:0]  w_bit_nx;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nx;
    logic [DATA_W-1:0] w_word_data;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] w_word_nx;
    logic              r_saida;
    logic              r_fim;
    logic              w_saida_nx;
    logic              w_fim_nx;
    logic              w_load;
    logic              w_tick;
    logic              w_last_nx;
    logic              w_state_chg;
`ifdef BITBAKERY_TX_PARITY_EN
    logic              r_par;
`endif

    assign w_state_chg = (w_state_nx != r_state);

    // The first edge after reset only arms the timer, so idle spans exactly GAP_BITS periods.
    bitbakery_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk         (clock),
        .rst_n       (reset),
        .i_en        (r_armed),
        .i_clear     (w_state_chg),
        .o_tick_c    (w_tick),
        .o_last_nx_c (w_last_nx)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= OCIOSO;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            OCIOSO: begin
                if (!GAP_EN || (w_tick && (r_bit == BIT_GAP_LAST))) begin
                    w_state_nx = INICIO;
                end
            end
            INICIO: begin
                if (w_tick) begin
                    w_state_nx = DADOS;
                end
            end
            DADOS: begin
                if (w_tick && (r_bit == BIT_DATA_LAST)) begin
`ifdef BITBAKERY_TX_PARITY_EN
                    w_state_nx = PARIDADE;
`else
                    w_state_nx = PARADA;
`endif
                end
            end
`ifdef BITBAKERY_TX_PARITY_EN
            PARIDADE: begin
                if (w_tick) begin
                    w_state_nx = PARADA;
                end
            end
`endif
            PARADA: begin
                if (w_tick) begin
                    if (GAP_EN) begin
                        w_state_nx = OCIOSO;
                    end else begin
                        w_state_nx = INICIO;
                    end
                end
            end
            default: w_state_nx = OCIOSO;
        endcase
    end

    // Next-cycle datapath and output values; outputs are registered from these.
    always_comb begin
        w_word_nx   = r_word;
        w_word_data = D0;
        w_load      = 1'b0;
        w_shift_nx  = r_shift;
        w_bit_nx    = r_bit;
        w_saida_nx  = STOP_LEVEL;
        w_fim_nx    = 1'b0;

        if ((r_state == PARADA) && w_tick) begin
            w_word_nx = r_word + WORD_W'(1);
        end

        case (w_word_nx)
            2'd0:    w_word_data = D0;
            2'd1:    w_word_data = D1;
            2'd2:    w_word_data = D2;
            default: w_word_data = D3;
        endcase

        w_load = (w_state_nx == INICIO) && w_state_chg;
        if (w_load) begin
            w_shift_nx = w_word_data;
        end else if ((r_state == DADOS) && w_tick) begin
            w_shift_nx = r_shift >> 1;
        end

        if (w_state_chg) begin
            w_bit_nx = '0;
        end else if (w_tick) begin
            w_bit_nx = r_bit + BIT_W'(1);
        end

        case (w_state_nx)
            INICIO:   w_saida_nx = START_LEVEL;
            DADOS:    w_saida_nx = w_shift_nx[0];
`ifdef BITBAKERY_TX_PARITY_EN
            PARIDADE: w_saida_nx = r_par;
`endif
            default:  w_saida_nx = STOP_LEVEL;
        endcase

        w_fim_nx = (w_state_nx == PARADA) && w_last_nx;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_armed <= 1'b0;
            r_bit   <= '0;
            r_shift <= '0;
            r_word  <= '0;
            r_saida <= STOP_LEVEL;
            r_fim   <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_word  <= w_word_nx;
            r_saida <= w_saida_nx;
            r_fim   <= w_fim_nx;
        end
    end

`ifdef BITBAKERY_TX_PARITY_EN
    // Parity is taken from the word as latched, so later input changes cannot disturb it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= ^w_word_data;
        end
    end
`endif

    assign saida_serial = r_saida;
    assign db_palavra   = r_word;
    assign fim_quadro   = r_fim;

endmodule

// File: tb/tb_bitbakery_serial_transmitter.sv
// Directed bench: default instance (4 clocks/bit, 1 gap bit) and a back-to-back instance (1 clock/bit, no gap).
module tb_bitbakery_serial_transmitter;

`ifdef BITBAKERY_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FL_D = (1 + FRAME_BITS) * 4;
    localparam int FL_F = FRAME_BITS;

    logic       clock   = 1'b0;
    logic       reset   = 1'b0;
    logic       reset_f = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00, d2 = 8'h00, d3 = 8'h00;
    logic [7:0] f0 = 8'h00, f1 = 8'h00, f2 = 8'h00, f3 = 8'h00;
    logic       saida, fim, saida_f, fim_f;
    logic [1:0] db, db_f;

    int total = 0;
    int bad   = 0;

    logic       s_line [0:255];
    logic       s_fim  [0:255];
    logic [1:0] s_db   [0:255];

    always #5 clock = ~clock;

    bitbakery_serial_transmitter u_dut (
        .clock        (clock),
        .reset        (reset),
        .D0           (d0),
        .D1           (d1),
        .D2           (d2),
        .D3           (d3),
        .saida_serial (saida),
        .db_palavra   (db),
        .fim_quadro   (fim)
    );

    bitbakery_serial_transmitter #(
        .CLKS_PER_BIT (1),
        .GAP_BITS     (0)
    ) u_fast (
        .clock        (clock),
        .reset        (reset_f),
        .D0           (f0),
        .D1           (f1),
        .D2           (f2),
        .D3           (f3),
        .saida_serial (saida_f),
        .db_palavra   (db_f),
        .fim_quadro   (fim_f)
    );

    // Expected line level for bit position p of a frame (0 = start bit), gap excluded.
    function automatic logic exp_bit(input logic [7:0] b, input int p);
        if (p == 0) return 1'b0;
        else if (p <= 8) return b[p-1];
        else if (p == FRAME_BITS - 1) return 1'b1;
        else return ^b;
    endfunction

    function automatic logic [7:0] decode_slow(input int base);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = s_line[base + 10 + 4 * k];
        return v;
    endfunction

    function automatic logic [7:0] decode_fast(input int base);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = s_line[base + 1 + k];
        return v;
    endfunction

    // Record n cycles; cycle 0 is the first edge after reset release. Optionally rewrite D0 at cycle chg_at.
    task automatic capture(input bit fast, input int n, input int chg_at, input logic [7:0] chg_val);
        for (int c = 0; c < n; c++) begin
            @(posedge clock);
            #1;
            s_line[c] = fast ? saida_f : saida;
            s_fim[c]  = fast ? fim_f : fim;
            s_db[c]   = fast ? db_f : db;
            if (c == chg_at) d0 = chg_val;
        end
    endtask

    task automatic do_reset_slow;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset   = 1'b0;
        reset_f = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        total++; if (saida !== 1'b1) begin bad++; $display("FAIL reset_line got=%b want=1", saida); end
        total++; if (db !== 2'd0) begin bad++; $display("FAIL reset_db got=%0d want=0", db); end
        total++; if (fim !== 1'b0) begin bad++; $display("FAIL reset_fim got=%b want=0", fim); end
        total++; if (saida_f !== 1'b1) begin bad++; $display("FAIL reset_fast_line got=%b want=1", saida_f); end
    endtask

    task automatic test_frame_a5;
        logic e;
        d0 = 8'hA5;
        do_reset_slow();
        capture(1'b0, FL_D, -1, 8'h00);
        for (int c = 0; c < FL_D; c++) begin
            e = (c < 4) ? 1'b1 : exp_bit(8'hA5, c / 4 - 1);
            total++; if (s_line[c] !== e) begin bad++; $display("FAIL a5_line cyc=%0d got=%b want=%b", c, s_line[c], e); end
            total++; if (s_fim[c] !== (c == FL_D - 1)) begin bad++; $display("FAIL a5_fim cyc=%0d got=%b want=%b", c, s_fim[c], (c == FL_D - 1)); end
            total++; if (s_db[c] !== 2'd0) begin bad++; $display("FAIL a5_db cyc=%0d got=%0d want=0", c, s_db[c]); end
        end
    endtask

    task automatic test_words;
        logic [7:0] words [4];
        logic [7:0] got;
        int         base, nfim;
        words = '{8'h00, 8'h5F, 8'hA0, 8'hC0};
        d0 = words[0]; d1 = words[1]; d2 = words[2]; d3 = words[3];
        do_reset_slow();
        capture(1'b0, 5 * FL_D, -1, 8'h00);
        for (int f = 0; f < 5; f++) begin
            base = f * FL_D;
            got  = decode_slow(base);
            total++; if (got !== words[f % 4]) begin bad++; $display("FAIL words_data frame=%0d got=%h want=%h", f, got, words[f % 4]); end
            total++; if (s_db[base] !== 2'(f % 4)) begin bad++; $display("FAIL words_db_first frame=%0d got=%0d want=%0d", f, s_db[base], f % 4); end
            total++; if (s_db[base + FL_D - 1] !== 2'(f % 4)) begin bad++; $display("FAIL words_db_last frame=%0d got=%0d want=%0d", f, s_db[base + FL_D - 1], f % 4); end
            total++; if (s_line[base + 4] !== 1'b0) begin bad++; $display("FAIL words_start frame=%0d got=%b want=0", f, s_line[base + 4]); end
            total++; if (s_line[base + FL_D - 1] !== 1'b1) begin bad++; $display("FAIL words_stop frame=%0d got=%b want=1", f, s_line[base + FL_D - 1]); end
            nfim = 0;
            for (int c = 0; c < FL_D; c++) if (s_fim[base + c] === 1'b1) nfim++;
            total++; if (nfim != 1 || s_fim[base + FL_D - 1] !== 1'b1) begin bad++; $display("FAIL words_fim frame=%0d got=%0d_pulses last=%b want=1_pulse last=1", f, nfim, s_fim[base + FL_D - 1]); end
        end
    endtask

    task automatic test_latch;
        logic [7:0] got;
        d0 = 8'h0F; d1 = 8'h11; d2 = 8'h22; d3 = 8'h33;
        do_reset_slow();
        capture(1'b0, 5 * FL_D, 10, 8'hF0);
        got = decode_slow(0);
        total++; if (got !== 8'h0F) begin bad++; $display("FAIL latch_inflight got=%h want=0f", got); end
        got = decode_slow(FL_D);
        total++; if (got !== 8'h11) begin bad++; $display("FAIL latch_d1 got=%h want=11", got); end
        got = decode_slow(4 * FL_D);
        total++; if (got !== 8'hF0) begin bad++; $display("FAIL latch_next_d0 got=%h want=f0", got); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] got;
        d0 = 8'h3C; d1 = 8'h00; d2 = 8'h00; d3 = 8'h00;
        do_reset_slow();
        // Stop at cycle 20 of the D1 frame: line is low (data bit 3 of 00) and db_palavra is 1.
        capture(1'b0, FL_D + 21, -1, 8'h00);
        total++; if (s_line[FL_D + 20] !== 1'b0) begin bad++; $display("FAIL mid_pre_line got=%b want=0", s_line[FL_D + 20]); end
        total++; if (s_db[FL_D + 20] !== 2'd1) begin bad++; $display("FAIL mid_pre_db got=%0d want=1", s_db[FL_D + 20]); end
        #2 reset = 1'b0;
        #1;
        total++; if (saida !== 1'b1) begin bad++; $display("FAIL mid_async_line got=%b want=1", saida); end
        total++; if (db !== 2'd0) begin bad++; $display("FAIL mid_async_db got=%0d want=0", db); end
        total++; if (fim !== 1'b0) begin bad++; $display("FAIL mid_async_fim got=%b want=0", fim); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        capture(1'b0, FL_D, -1, 8'h00);
        total++; if (s_line[3] !== 1'b1) begin bad++; $display("FAIL mid_idle3 got=%b want=1", s_line[3]); end
        total++; if (s_line[4] !== 1'b0) begin bad++; $display("FAIL mid_start4 got=%b want=0", s_line[4]); end
        got = decode_slow(0);
        total++; if (got !== 8'h3C) begin bad++; $display("FAIL mid_restart_d0 got=%h want=3c", got); end
        total++; if (s_db[FL_D - 1] !== 2'd0) begin bad++; $display("FAIL mid_restart_db got=%0d want=0", s_db[FL_D - 1]); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] words [4];
        logic [7:0] got;
        logic       e;
        int         pos, fr;
        words = '{8'h96, 8'h01, 8'h80, 8'h3C};
        f0 = words[0]; f1 = words[1]; f2 = words[2]; f3 = words[3];
        reset_f = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_f = 1'b1;
        capture(1'b1, 4 * FL_F + 1, -1, 8'h00);
        for (int c = 0; c < 4 * FL_F + 1; c++) begin
            pos = c % FL_F;
            fr  = c / FL_F;
            e   = exp_bit(words[fr % 4], pos);
            total++; if (s_line[c] !== e) begin bad++; $display("FAIL b2b_line cyc=%0d got=%b want=%b", c, s_line[c], e); end
            total++; if (s_fim[c] !== (pos == FL_F - 1)) begin bad++; $display("FAIL b2b_fim cyc=%0d got=%b want=%b", c, s_fim[c], (pos == FL_F - 1)); end
            total++; if (s_db[c] !== 2'(fr % 4)) begin bad++; $display("FAIL b2b_db cyc=%0d got=%0d want=%0d", c, s_db[c], fr % 4); end
        end
        for (int f = 0; f < 4; f++) begin
            got = decode_fast(f * FL_F);
            total++; if (got !== words[f]) begin bad++; $display("FAIL b2b_data frame=%0d got=%h want=%h", f, got, words[f]); end
        end
    endtask

`ifdef BITBAKERY_TX_PARITY_EN
    task automatic test_parity;
        logic e;
        d0 = 8'h07;
        do_reset_slow();
        capture(1'b0, FL_D, -1, 8'h00);
        for (int c = 36; c < 48; c++) begin
            e = (c < 40) ? 1'b0 : 1'b1;
            total++; if (s_line[c] !== e) begin bad++; $display("FAIL parity_line cyc=%0d got=%b want=%b", c, s_line[c], e); end
            total++; if (s_fim[c] !== (c == 47)) begin bad++; $display("FAIL parity_fim cyc=%0d got=%b want=%b", c, s_fim[c], (c == 47)); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame_a5();
        test_words();
        test_latch();
        test_reset_mid();
        test_back_to_back();
`ifdef BITBAKERY_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitbakery_serial_transmitter.md
Name:
bitbakery_serial_transmitter

Overview:
- Free-running asynchronous serial (UART-style) transmitter for the BitBakery top level.
- Cyclically sends four 8-bit status words D0, D1, D2, D3, D0, … on one output line, one frame per word.
- Carries minigame, state, move and difficulty telemetry to the external host.
- Runs on the divided system clock; needs no start command.

Parameters:
- CLKS_PER_BIT, default 4: clock cycles per serial bit period; legal range ≥ 1.
- GAP_BITS, default 1: idle (high) bit periods inserted before every frame; legal range ≥ 0.

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- D0, input, 8: word 0, sent first after reset.
- D1, input, 8: word 1.
- D2, input, 8: word 2.
- D3, input, 8: word 3.
- saida_serial, output, 1: serial line, idle high.
- db_palavra, output, 2: index of the word currently being sent, or about to be sent.
- fim_quadro, output, 1: one-cycle pulse on the last cycle of each stop bit.

Behaviour:
- Reset asserted (reset=0), effective immediately without a clock edge:
  - saida_serial=1, db_palavra=0, fim_quadro=0.
  - Bit-period counter=0, state=OCIOSO.
- States:
  - OCIOSO: line high for GAP_BITS×CLKS_PER_BIT cycles. If GAP_BITS=0, it lasts 0 cycles (go straight to INICIO).
  - INICIO: start bit 0.
  - DADOS: 8 bits, LSB first.
  - PARIDADE: present only with the optional feature.
  - PARADA: stop bit 1.
- Every non-idle state holds each bit for exactly CLKS_PER_BIT cycles.
- Latch: on the transition into INICIO, D[db_palavra] is captured into an 8-bit shift register.
  - Input changes after the capture do not affect the frame in flight.
- Frame length:
  - Without parity: (GAP_BITS+10)×CLKS_PER_BIT cycles.
  - With parity: (GAP_BITS+11)×CLKS_PER_BIT cycles.
- Timing with defaults, cycles numbered from the first edge after reset release:
  - Cycles 0–3: idle.
  - Cycles 4–7: start bit.
  - Data bit k occupies cycles 8+4k … 11+4k.
  - Cycles 40–43: stop bit.
- End of PARADA:
  - fim_quadro=1 for exactly that last cycle.
  - On the following edge, db_palavra increments modulo 4 (3→0 wraps) and state returns to OCIOSO.
- saida_serial is driven from a register: no combinational glitches, no extra latency beyond the bit schedule above.
- Reset mid-frame: frame is aborted at once, line goes high, and sequence restarts with D0 after reset release.
- Counters use ceil(log2(CLKS_PER_BIT)) bits, minimum 1; no overflow beyond CLKS_PER_BIT-1.

Optional Feature:
- Macro: BITBAKERY_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 latched data bits) is sent between the last data bit and the stop bit, for CLKS_PER_BIT cycles.
- Undefined: no PARIDADE state exists; the stop bit follows data bit 7 directly.
- All other timing and port behaviour is identical in both builds.

Decomposition:
- Package bitbakery_serial_pkg holds:
  - DATA_W=8 and NUM_WORDS=4.
  - The state encoding: OCIOSO, INICIO, DADOS, PARIDADE, PARADA.
  - The constant STOP_LEVEL=1'b1.
- One sub-module, bitbakery_baud_tick:
  - Counts 0…CLKS_PER_BIT-1 and pulses on the terminal count.
  - Clears when the FSM changes state.
  - Same async active-low reset.

Test Plan:
- Reset then release, D0=8'hA5, defaults:
  - saida_serial high for cycles 0–3, low for 4–7.
  - Data line sequence 1,0,1,0,0,1,0,1 in 4-cycle bits.
  - High for 40–43; fim_quadro=1 at cycle 43 only.
- Distinct words D0=00, D1=5F, D2=A0, D3=C0:
  - Four consecutive decoded frames equal 00, 5F, A0, C0, then 00 again.
  - db_palavra steps 0→1→2→3→0.
- Change D0 from 8'h0F to 8'hF0 at cycle 10, mid-frame: decoded frame is 0F; the next D0 frame is F0.
- Assert reset at cycle 20:
  - saida_serial=1 and db_palavra=0 with no clock edge required.
  - After release, first frame is D0 again, start bit at cycle 4.
- GAP_BITS=0, CLKS_PER_BIT=1:
  - Start bit at cycle 0.
  - Frames back-to-back every 10 cycles, stop bit immediately followed by the next start bit.
- With BITBAKERY_TX_PARITY_EN, D0=8'h07: parity bit=1 in cycles 40–43; stop bit in cycles 44–47.
